// File: rtl/bpsk_awgn_link_if.sv
// Byte-wide data bundle of the BPSK/AWGN link: transmit byte in, decided byte out.
// The master drives data_in and the link (slave) returns data_out.
interface bpsk_awgn_link_if;
   logic [7:0] data_in;
   logic [7:0] data_out;

   modport master (output data_in, input data_out);
   modport slave  (input data_in, output data_out);
endinterface

// File: rtl/bpsk_awgn_link.sv
// 8-lane BPSK link model: antipodal transmitter, shared LFSR-based noise sample,
// hard-decision sign slicer. Two-edge latency, one byte per cycle.
module bpsk_awgn_link #(
   parameter int          AMPLITUDE   = 128,
   parameter int          NOISE_SHIFT = 2,
   parameter logic [31:0] SEED        = 32'hACE12468
) (
   input  logic            clk,
   input  logic            reset,
   bpsk_awgn_link_if.slave link
);

   // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
   localparam logic [31:0]        LFSR_INIT = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;
   localparam logic signed [10:0] SYM_POS   = 11'(AMPLITUDE);
   localparam logic signed [10:0] SYM_NEG   = 11'(-AMPLITUDE);

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   function automatic logic signed [10:0] noise_raw(input logic [31:0] s);
      return {3'b000, s[7:0]} + {3'b000, s[15:8]} + {3'b000, s[23:16]}
           + {3'b000, s[31:24]} - 11'd510;
   endfunction

   logic [31:0]        r_lfsr;
   logic signed [10:0] r_noise;
   logic signed [10:0] r_sym    [8];
   logic signed [10:0] w_rxsym  [8];
   logic signed [10:0] w_raw;
   logic [7:0]         r_data_out;

   assign w_raw = noise_raw(r_lfsr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lfsr  <= LFSR_INIT;
         r_noise <= 11'sd0;
      end else begin
         r_lfsr  <= lfsr_next(r_lfsr);
         r_noise <= w_raw >>> NOISE_SHIFT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            r_sym[i] <= 11'sd0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            r_sym[i] <= link.data_in[i] ? SYM_POS : SYM_NEG;
         end
      end
   end

   // One noise sample is shared by all lanes; |sym|+|noise| < 1024 so no wrap.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_rxsym[i] = r_sym[i] + r_noise;
      end
   end

   // Sign slicer: a received value of exactly zero decides as 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data_out <= 8'h00;
      end else begin
         for (int i = 0; i < 8; i++) begin
            r_data_out[i] <= ~w_rxsym[i][10];
         end
      end
   end

   assign link.data_out = r_data_out;

endmodule

// File: tb/tb_bpsk_awgn_link.sv
// Directed bench for bpsk_awgn_link: default, heavy-noise and zero-boundary instances
// checked against hand values and a behavioural link model.
module tb_bpsk_awgn_link;

   localparam int          AMP   [3] = '{128, 128, 127};
   localparam int          SHIFT [3] = '{2, 0, 2};
   localparam logic [31:0] SEEDS [3] = '{32'hACE12468, 32'hACE12468, 32'h00000002};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bpsk_awgn_link_if if_def ();
   bpsk_awgn_link_if if_hvy ();
   bpsk_awgn_link_if if_bnd ();

   bpsk_awgn_link #(.AMPLITUDE(AMP[0]), .NOISE_SHIFT(SHIFT[0]), .SEED(SEEDS[0]))
      u_def (.clk(clk), .reset(reset), .link(if_def));
   bpsk_awgn_link #(.AMPLITUDE(AMP[1]), .NOISE_SHIFT(SHIFT[1]), .SEED(SEEDS[1]))
      u_hvy (.clk(clk), .reset(reset), .link(if_hvy));
   bpsk_awgn_link #(.AMPLITUDE(AMP[2]), .NOISE_SHIFT(SHIFT[2]), .SEED(SEEDS[2]))
      u_bnd (.clk(clk), .reset(reset), .link(if_bnd));

   int vectors     = 0;
   int miscompares = 0;
   int hvy_errs    = 0;
   int hvy_bits    = 0;
   int m_valid     = 0;
   bit rand_bnd    = 1'b0;

   logic [31:0] m_lfsr  [3];
   int          m_noise [3];
   int          m_sym   [3][8];
   logic [7:0]  m_out   [3];
   logic [7:0]  m_hist  [3][2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_next(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   function automatic int ref_noise(input logic [31:0] s, input int sh);
      int raw;
      raw = int'(s[7:0]) + int'(s[15:8]) + int'(s[23:16]) + int'(s[31:24]) - 510;
      return raw >>> sh;
   endfunction

   function automatic logic [31:0] n11(input int v);
      logic [10:0] t;
      t = 11'(v);
      return {21'b0, t};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_lfsr[k]  = (SEEDS[k] == 32'h0) ? 32'h1 : SEEDS[k];
         m_noise[k] = 0;
         m_out[k]   = 8'h00;
         for (int i = 0; i < 8; i++) m_sym[k][i] = 0;
      end
      m_valid = 0;
   endtask

   task automatic model_edge(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
      logic [7:0] din [3];
      din[0] = d0; din[1] = d1; din[2] = d2;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 8; i++) m_out[k][i] = ((m_sym[k][i] + m_noise[k]) >= 0);
         m_noise[k] = ref_noise(m_lfsr[k], SHIFT[k]);
         m_lfsr[k]  = ref_next(m_lfsr[k]);
         for (int i = 0; i < 8; i++) m_sym[k][i] = din[k][i] ? AMP[k] : -AMP[k];
         m_hist[k][1] = m_hist[k][0];
         m_hist[k][0] = din[k];
      end
      m_valid++;
   endtask

   task automatic check_all();
      chk("def_lfsr",  u_def.r_lfsr, m_lfsr[0]);
      chk("hvy_lfsr",  u_hvy.r_lfsr, m_lfsr[1]);
      chk("bnd_lfsr",  u_bnd.r_lfsr, m_lfsr[2]);
      chk("def_lfsr_nonzero", {31'b0, u_def.r_lfsr != 32'h0}, 32'h1);
      chk("def_noise", {21'b0, u_def.r_noise}, n11(m_noise[0]));
      chk("hvy_noise", {21'b0, u_hvy.r_noise}, n11(m_noise[1]));
      chk("bnd_noise", {21'b0, u_bnd.r_noise}, n11(m_noise[2]));
      chk("def_dout",  {24'b0, if_def.data_out}, {24'b0, m_out[0]});
      chk("hvy_dout",  {24'b0, if_hvy.data_out}, {24'b0, m_out[1]});
      chk("bnd_dout",  {24'b0, if_bnd.data_out}, {24'b0, m_out[2]});
      if (m_valid >= 2) begin
         chk("def_error_free", {24'b0, if_def.data_out}, {24'b0, m_hist[0][1]});
         hvy_errs += $countones(if_hvy.data_out ^ m_hist[1][1]);
         hvy_bits += 8;
      end
   endtask

   // Inputs are stable across the rising edge; outputs are checked on the falling edge.
   task automatic step();
      logic [7:0] d0, d1, d2;
      d0 = if_def.data_in; d1 = if_hvy.data_in; d2 = if_bnd.data_in;
      @(posedge clk);
      if (reset) model_reset();
      else       model_edge(d0, d1, d2);
      @(negedge clk);
      check_all();
      if_hvy.data_in = 8'($urandom);
      if (rand_bnd) if_bnd.data_in = 8'($urandom);
   endtask

   task automatic run_def(input logic [7:0] val, input int n);
      if_def.data_in = val;
      for (int j = 0; j < n; j++) begin
         step();
         if (j >= 1) chk("def_hold", {24'b0, if_def.data_out}, {24'b0, val});
      end
   endtask

   initial begin
      reset          = 1'b0;
      if_def.data_in = 8'hFF;
      if_hvy.data_in = 8'hFF;
      if_bnd.data_in = 8'hFF;
      m_hist[0][0] = 8'h00; m_hist[0][1] = 8'h00;
      m_hist[1][0] = 8'h00; m_hist[1][1] = 8'h00;
      m_hist[2][0] = 8'h00; m_hist[2][1] = 8'h00;
      model_reset();

      #1 reset = 1'b1;
      #1;
      chk("rst_async_dout", {24'b0, if_def.data_out}, 32'h0);
      step();
      step();
      chk("rst_dout_def", {24'b0, if_def.data_out}, 32'h0);
      chk("rst_noise_def", {21'b0, u_def.r_noise}, 32'h0);
      chk("rst_lfsr_def", u_def.r_lfsr, 32'hACE12468);
      chk("rst_lfsr_bnd", u_bnd.r_lfsr, 32'h00000002);

      // Release: zeroed symbols slice as all ones on the first edge.
      reset          = 1'b0;
      if_def.data_in = 8'hAA;
      if_bnd.data_in = 8'h0F;
      step();
      chk("bnd_noise_m127", {21'b0, u_bnd.r_noise}, 32'h00000781);
      chk("bnd_rxsym_zero", {21'b0, u_bnd.w_rxsym[0]}, 32'h0);
      chk("first_edge_dout", {24'b0, if_bnd.data_out}, 32'hFF);
      step();
      chk("bnd_zero_is_one", {24'b0, if_bnd.data_out}, 32'h0F);
      rand_bnd = 1'b1;

      run_def(8'hAA, 13);
      run_def(8'h66, 5);
      run_def(8'h00, 5);
      run_def(8'h3F, 5);
      run_def(8'h00, 4);

      if_def.data_in = 8'hFF;
      step();
      chk("latency_edge_n",  {24'b0, if_def.data_out}, 32'h00);
      step();
      chk("latency_edge_n1", {24'b0, if_def.data_out}, 32'hFF);

      // Mid-stream reset between clock edges.
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("midrst_async_def", {24'b0, if_def.data_out}, 32'h0);
      chk("midrst_async_hvy", {24'b0, if_hvy.data_out}, 32'h0);
      @(negedge clk);
      chk("midrst_lfsr_seed", u_def.r_lfsr, 32'hACE12468);
      reset = 1'b0;

      for (int n = 0; n < 10000; n++) begin
         if_def.data_in = 8'($urandom);
         step();
      end

      chk("hvy_ber_nonzero",    {31'b0, hvy_errs > 0}, 32'h1);
      chk("hvy_ber_below_half", {31'b0, (hvy_errs * 2) < hvy_bits}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
